// File: rtl/rename_alias_table_pkg.sv
// rtl/rename_alias_table_pkg.sv - shared sizes, opcodes and helpers for the rename alias table
// Purpose: one place for the physical register count, arch window, free list depth,
//          destination-less opcodes, and small helpers used by the top and the free list.
// Ports:   none (package).
`ifndef PHYS_REGS
`define PHYS_REGS 32
`endif

package rename_alias_table_pkg;

    localparam int PHYS_REGS = `PHYS_REGS;
    localparam int PW        = $clog2(PHYS_REGS);
    localparam int N_ARCH    = 10;               // arch regs 2..11 are renamed
    localparam int FL_DEPTH  = PHYS_REGS - 12;   // phys 0..11 are mapped at reset

    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;
    localparam logic [3:0] OP_CTERM = 4'hE;
    localparam logic [3:0] OP_TERM  = 4'hF;

    // Only arch 2..11 own a RAT entry; 0/1 are hardwired and 12..15 have no entry.
    function automatic logic arch_ok(input logic [3:0] a);
        return (a >= 4'd2) && (a <= 4'(N_ARCH + 1));
    endfunction

    // Advance a free list pointer by 0..2 entries, wrapping at FL_DEPTH.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + {{(PW-1){1'b0}}, n};
        if (s >= (PW+1)'(FL_DEPTH)) begin
            s = s - (PW+1)'(FL_DEPTH);
        end
        return s[PW-1:0];
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - 2-pop/2-push circular free list of physical registers
// Purpose: holds unallocated phys regs; head entries are offered combinationally,
//          pops/pushes take effect at the clock edge. Reset preloads phys 12.. ascending.
// Ports:   clk, rst         clock, async active-high reset
//          i_pop_n          entries consumed this cycle (0..2)
//          i_push_valid     per-slot push strobes, slot0 enters before slot1
//          i_push_phys      pushed phys regs, slot0 in low PW bits
//          o_head0/o_head1  head entry and the one after it
//          o_count          current occupancy
module rename_free_list
    import rename_alias_table_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_pop_n,
    input  logic [1:0]        i_push_valid,
    input  logic [2*PW-1:0]   i_push_phys,
    output logic [PW-1:0]     o_head0,
    output logic [PW-1:0]     o_head1,
    output logic [PW:0]       o_count
);

    logic [PW-1:0] r_mem [FL_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic [1:0]    w_push_n;
    logic [PW-1:0] w_tail1;

    assign w_push_n = {1'b0, i_push_valid[0]} + {1'b0, i_push_valid[1]};
    // Slot1 lands right after slot0, or at the tail itself when slot0 is idle.
    assign w_tail1  = ptr_add(r_tail, {1'b0, i_push_valid[0]});

    assign o_head0  = r_mem[r_head];
    assign o_head1  = r_mem[ptr_add(r_head, 2'd1)];
    assign o_count  = r_count;

    // Reads come from registered storage, so a same-cycle push is never popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_mem[i] <= PW'(i + 12);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= (PW+1)'(FL_DEPTH);
        end else begin
            if (i_push_valid[0]) begin
                r_mem[r_tail] <= i_push_phys[PW-1:0];
            end
            if (i_push_valid[1]) begin
                r_mem[w_tail1] <= i_push_phys[2*PW-1:PW];
            end
            r_head  <= ptr_add(r_head, i_pop_n);
            r_tail  <= ptr_add(r_tail, w_push_n);
            r_count <= r_count - (PW+1)'(i_pop_n) + (PW+1)'(w_push_n);
        end
    end

endmodule

// File: rtl/rename_alias_table.sv
// rtl/rename_alias_table.sv - register alias table and destination allocator
// Purpose: holds arch->phys mappings and ready bits for arch 2..11, allocates up to two
//          destination phys regs per microop from the free list, marks writebacks done.
// Ports:   clk, rst                  clock, async active-high reset
//          in_valid/in_ready         microop handshake, fire = in_valid & in_ready
//          microop                   opcode [23:20], slot1 dest [19:16], slot0 dest [15:12]
//          dest_phys/dest_old/dest_en  per-slot allocation, valid in the fire cycle
//          rat_done/rat_aliases      registered ready bits and mappings (pre-update in fire)
//          wb_valid/wb_phys          writeback broadcast
//          free_valid/free_phys      regs returned by retire
//          free_count                free list occupancy
module rename_alias_table
    import rename_alias_table_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [23:0]          microop,
    output logic [2*PW-1:0]      dest_phys,
    output logic [2*PW-1:0]      dest_old,
    output logic [1:0]           dest_en,
    output logic [N_ARCH-1:0]    rat_done,
    output logic [N_ARCH*PW-1:0] rat_aliases,
    input  logic                 wb_valid,
    input  logic [PW-1:0]        wb_phys,
    input  logic [1:0]           free_valid,
    input  logic [2*PW-1:0]      free_phys,
    output logic [PW:0]          free_count
);

    logic [PW-1:0]     r_alias [N_ARCH];
    logic [N_ARCH-1:0] r_done;

    logic [3:0]    w_op;
    logic [3:0]    w_arch0;
    logic [3:0]    w_arch1;
    logic          w_req0;
    logic          w_req1;
    logic [1:0]    w_need;
    logic          w_fire;
    logic          w_en0;
    logic          w_en1;
    logic [1:0]    w_pop_n;
    logic [PW-1:0] w_head0;
    logic [PW-1:0] w_head1;
    logic [PW-1:0] w_phys0;
    logic [PW-1:0] w_phys1;
    logic [PW-1:0] w_old0;
    logic [PW-1:0] w_old1;
    logic          w_unused_ok;

    assign w_op    = microop[23:20];
    assign w_arch1 = microop[19:16];
    assign w_arch0 = microop[15:12];
    assign w_unused_ok = &{1'b0, microop[11:0]};

    assign w_req0 = !(w_op == OP_STORE || w_op == OP_CTERM || w_op == OP_TERM) && arch_ok(w_arch0);
    assign w_req1 = !(w_op == OP_LOAD || w_op == OP_STORE || w_op == OP_CTERM || w_op == OP_TERM)
                    && arch_ok(w_arch1);

    assign w_need   = {1'b0, w_req0} + {1'b0, w_req1};
    // Registered count only: regs freed this cycle cannot fund this cycle's microop.
    assign in_ready = (free_count >= (PW+1)'(w_need));
    // Holding dest_en low through reset keeps in-flight allocations from escaping.
    assign w_fire   = in_valid & in_ready & ~rst;
    assign w_en0    = w_fire & w_req0;
    assign w_en1    = w_fire & w_req1;
    assign w_pop_n  = {1'b0, w_en0} + {1'b0, w_en1};

    // When slot0 is idle, slot1 takes the head so no free entry is skipped.
    assign w_phys0 = w_head0;
    assign w_phys1 = w_req0 ? w_head1 : w_head0;

    always_comb begin
        w_old0 = '0;
        w_old1 = '0;
        for (int i = 0; i < N_ARCH; i++) begin
            if (w_arch0 == 4'(i + 2)) w_old0 = r_alias[i];
            if (w_arch1 == 4'(i + 2)) w_old1 = r_alias[i];
        end
        if (!w_req0) w_old0 = '0;
        if (!w_req1) begin
            w_old1 = '0;
        end else if (w_req0 && (w_arch0 == w_arch1)) begin
            // Slot1 overwrites slot0's fresh mapping, so slot0's reg is what retire frees.
            w_old1 = w_phys0;
        end
    end

    assign dest_phys = {w_phys1, w_phys0};
    assign dest_old  = {w_old1, w_old0};
    assign dest_en   = {w_en1, w_en0};

    rename_free_list u_free_list (
        .clk          (clk),
        .rst          (rst),
        .i_pop_n      (w_pop_n),
        .i_push_valid (free_valid),
        .i_push_phys  (free_phys),
        .o_head0      (w_head0),
        .o_head1      (w_head1),
        .o_count      (free_count)
    );

    // Priority per entry: slot1 rename, slot0 rename, then writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ARCH; i++) begin
                r_alias[i] <= PW'(i + 2);
            end
            r_done <= '1;
        end else begin
            for (int i = 0; i < N_ARCH; i++) begin
                if (w_en1 && (w_arch1 == 4'(i + 2))) begin
                    r_alias[i] <= w_phys1;
                    r_done[i]  <= 1'b0;
                end else if (w_en0 && (w_arch0 == 4'(i + 2))) begin
                    r_alias[i] <= w_phys0;
                    r_done[i]  <= 1'b0;
                end else if (wb_valid && (r_alias[i] == wb_phys)) begin
                    r_done[i]  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rat_aliases = '0;
        for (int i = 0; i < N_ARCH; i++) begin
            rat_aliases[i*PW +: PW] = r_alias[i];
        end
    end

    assign rat_done = r_done;

endmodule

// File: tb/tb_rename_alias_table.sv
// tb/tb_rename_alias_table.sv - scoreboard bench for rename_alias_table
module tb_rename_alias_table;
    import rename_alias_table_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [23:0]          microop;
    logic [2*PW-1:0]      dest_phys;
    logic [2*PW-1:0]      dest_old;
    logic [1:0]           dest_en;
    logic [N_ARCH-1:0]    rat_done;
    logic [N_ARCH*PW-1:0] rat_aliases;
    logic                 wb_valid;
    logic [PW-1:0]        wb_phys;
    logic [1:0]           free_valid;
    logic [2*PW-1:0]      free_phys;
    logic [PW:0]          free_count;

    rename_alias_table dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .microop     (microop),
        .dest_phys   (dest_phys),
        .dest_old    (dest_old),
        .dest_en     (dest_en),
        .rat_done    (rat_done),
        .rat_aliases (rat_aliases),
        .wb_valid    (wb_valid),
        .wb_phys     (wb_phys),
        .free_valid  (free_valid),
        .free_phys   (free_phys),
        .free_count  (free_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit                   ready;
        logic [1:0]           en;
        int                   p0, p1, o0, o1;
        logic [N_ARCH*PW-1:0] aliases;
        logic [N_ARCH-1:0]    done;
        int                   count;
    } exp_t;

    exp_t exp_q[$];
    int   m_alias [N_ARCH];
    bit   m_done  [N_ARCH];
    int   fl[$];
    int   retire_q[$];
    logic [N_ARCH*PW-1:0] rst_map;

    task automatic model_reset();
        for (int i = 0; i < N_ARCH; i++) begin
            m_alias[i] = i + 2;
            m_done[i]  = 1'b1;
        end
        fl.delete();
        for (int p = 12; p < PHYS_REGS; p++) fl.push_back(p);
        retire_q.delete();
        exp_q.delete();
    endtask

    // Called at posedge+1: drive, predict, check at negedge, update model at next posedge.
    task automatic step(input bit v, input logic [23:0] uop, input bit wbv, input int wbp,
                        input logic [1:0] fv);
        int a0, a1, op, need, p0, p1, o0, o1, f0, f1;
        bit r0, r1, rdy, fire;
        logic [1:0] fvv;
        exp_t e, g;
        op = int'(uop[23:20]); a1 = int'(uop[19:16]); a0 = int'(uop[15:12]);
        r0 = (op < 13) && (a0 >= 2) && (a0 <= 11);
        r1 = (op < 12) && (a1 >= 2) && (a1 <= 11);
        f0 = 0; f1 = 0; fvv = 2'b00;
        if (fv[0] && retire_q.size() > 0) begin f0 = retire_q.pop_front(); fvv[0] = 1'b1; end
        if (fv[1] && retire_q.size() > 0) begin f1 = retire_q.pop_front(); fvv[1] = 1'b1; end
        if ((fvv[0] && f0 < 2) || (fvv[1] && f1 < 2) ||
            (fl.size() + int'(fvv[0]) + int'(fvv[1]) > FL_DEPTH))
            chk("free_legal", 0, 1);
        in_valid   = v;
        microop    = uop;
        wb_valid   = wbv;
        wb_phys    = PW'(wbp);
        free_valid = fvv;
        free_phys  = {PW'(f1), PW'(f0)};

        need = int'(r0) + int'(r1);
        rdy  = fl.size() >= need;
        fire = v && rdy;
        p0 = (fl.size() > 0) ? fl[0] : 0;
        p1 = r0 ? ((fl.size() > 1) ? fl[1] : 0) : p0;
        o0 = r0 ? m_alias[a0-2] : 0;
        o1 = r1 ? ((r0 && a0 == a1) ? p0 : m_alias[a1-2]) : 0;
        e.ready = rdy;
        e.en    = fire ? {r1, r0} : 2'b00;
        e.p0 = p0; e.p1 = p1; e.o0 = o0; e.o1 = o1;
        for (int i = 0; i < N_ARCH; i++) begin
            e.aliases[i*PW +: PW] = PW'(m_alias[i]);
            e.done[i] = m_done[i];
        end
        e.count = fl.size();
        exp_q.push_back(e);

        @(negedge clk);
        g = exp_q.pop_front();
        chk("in_ready", in_ready, g.ready);
        chk("dest_en", dest_en, g.en);
        if (g.en[0]) begin
            chk("dest_phys0", dest_phys[PW-1:0], g.p0);
            chk("dest_old0", dest_old[PW-1:0], g.o0);
        end
        if (g.en[1]) begin
            chk("dest_phys1", dest_phys[2*PW-1:PW], g.p1);
            chk("dest_old1", dest_old[2*PW-1:PW], g.o1);
        end
        chk("rat_aliases", rat_aliases, g.aliases);
        chk("rat_done", rat_done, g.done);
        chk("free_count", free_count, g.count);

        @(posedge clk);
        for (int i = 0; i < N_ARCH; i++)
            if (wbv && m_alias[i] == wbp) m_done[i] = 1'b1;
        if (fire && r0) begin
            void'(fl.pop_front());
            m_alias[a0-2] = p0; m_done[a0-2] = 1'b0; retire_q.push_back(o0);
        end
        if (fire && r1) begin
            void'(fl.pop_front());
            m_alias[a1-2] = p1; m_done[a1-2] = 1'b0; retire_q.push_back(o1);
        end
        if (fvv[0]) fl.push_back(f0);
        if (fvv[1]) fl.push_back(f1);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; microop = '0; wb_valid = 1'b0; wb_phys = '0;
        free_valid = '0; free_phys = '0;
        for (int i = 0; i < N_ARCH; i++) rst_map[i*PW +: PW] = PW'(i + 2);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_aliases", rat_aliases, rst_map);
        chk("rst_done", rat_done, 10'h3FF);
        chk("rst_count", free_count, 20);
        step(0, 24'h000000, 0, 0, 2'b00);

        // two-dest rename r2/r3
        step(1, 24'h032000, 0, 0, 2'b00);
        chk("t1_alias0", rat_aliases[PW-1:0], 12);
        chk("t1_alias1", rat_aliases[2*PW-1:PW], 13);
        chk("t1_done", rat_done[1:0], 2'b00);
        chk("t1_count", free_count, 18);

        // writeback, then writeback racing a rename of the same entry
        step(0, 24'h000000, 1, 12, 2'b00);
        chk("wb_done0", rat_done[0], 1'b1);
        step(1, 24'hC02000, 1, 12, 2'b00);
        chk("wb_rename_done0", rat_done[0], 1'b0);

        // store: no dests
        step(1, 24'hD32000, 0, 0, 2'b00);

        // drain the free list to zero
        for (int k = 0; fl.size() >= 2 && k < 40; k++)
            step(1, {4'h0, 4'(4 + k % 8), 4'(5 + k % 7), 12'h000}, 0, 0, 2'b00);
        if (fl.size() == 1) step(1, 24'hC06000, 0, 0, 2'b00);
        chk("drained", free_count, 0);
        // blocked with a same-cycle free, then accepted from the wrapped list
        step(1, 24'h032000, 0, 0, 2'b11);
        step(1, 24'h032000, 0, 0, 2'b00);

        // same arch in both slots
        repeat (4) step(0, 24'h000000, 0, 0, 2'b11);
        step(1, 24'h055000, 0, 0, 2'b00);

        // random burst
        repeat (200)
            step($urandom_range(0, 3) != 0,
                 {4'($urandom_range(0, 15)), 4'($urandom_range(0, 11)),
                  4'($urandom_range(0, 11)), 12'($urandom)},
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, PHYS_REGS - 1)),
                 2'($urandom_range(0, 3)));

        // reset mid-burst takes effect without a clock edge
        in_valid = 1'b1; microop = 24'h032000;
        rst = 1'b1;
        #1;
        chk("midrst_aliases", rat_aliases, rst_map);
        chk("midrst_done", rat_done, 10'h3FF);
        chk("midrst_count", free_count, 20);
        chk("midrst_dest_en", dest_en, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step(1, 24'h032000, 0, 0, 2'b00);
        chk("post_rst_alias0", rat_aliases[PW-1:0], 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
